// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl
//   Clocked line-follower motor controller. Synchronises and debounces the inductive line
//   sensors and the proximity sensor, decodes a steering command, sequences it through a
//   follow / obstacle / resume / search FSM and gates the H-bridge with a PWM enable.
// Ports
//   i_clk        system clock
//   i_reset      synchronous, active-high reset
//   i_enable     run request; low forces IDLE at the next edge
//   i_induct     raw line sensors (bit 0 rightmost), 1 = line, asynchronous
//   i_proxim     raw obstacle sensor, 1 = obstacle, asynchronous
//   i_speed      PWM duty, taken once per PWM period
//   o_motor_dir  {La,Lb,Ra,Rb}: STOP=0000 FWD=0110 LEFT=1010 RIGHT=0101
//   o_motor_pwm  H-bridge enable
//   o_state      IDLE=0 FOLLOW=1 OBST=2 RESUME=3 SEARCH=4
//   o_line_lost  high while searching for the line
module line_follow_ctrl #(
    parameter int unsigned N_SENSORS     = 3,
    parameter int unsigned DEBOUNCE      = 8,
    parameter int unsigned LOST_CYCLES   = 1024,
    parameter int unsigned RESUME_CYCLES = 256,
    parameter int unsigned PWM_W         = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [N_SENSORS-1:0] i_induct,
    input  logic                 i_proxim,
    input  logic [PWM_W-1:0]     i_speed,
    output logic [3:0]           o_motor_dir,
    output logic                 o_motor_pwm,
    output logic [2:0]           o_state,
    output logic                 o_line_lost
);

    localparam int unsigned NI  = N_SENSORS + 1;        // line sensors plus proximity
    localparam int unsigned DBW = $clog2(DEBOUNCE + 1);
    localparam int unsigned CW  = $clog2(N_SENSORS) + 1;
    localparam int unsigned LW  = $clog2(LOST_CYCLES + 1);
    localparam int unsigned RW  = $clog2(RESUME_CYCLES + 1);
    localparam int          CTR = int'(N_SENSORS / 2);

    localparam logic [3:0] DIR_STOP  = 4'b0000;
    localparam logic [3:0] DIR_FWD   = 4'b0110;
    localparam logic [3:0] DIR_LEFT  = 4'b1010;
    localparam logic [3:0] DIR_RIGHT = 4'b0101;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFollow = 3'd1,
        StObst   = 3'd2,
        StResume = 3'd3,
        StSearch = 3'd4
    } state_e;

    // ---------------------------------------------------------------- input path
    // Proximity rides along as the top bit so it gets the same sync + debounce.
    logic [NI-1:0]  r_sync1, r_sync2, r_filt;
    logic [DBW-1:0] r_db_cnt [NI];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
            for (int i = 0; i < NI; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= {i_proxim, i_induct};
            r_sync2 <= r_sync1;
            for (int i = 0; i < NI; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DBW'(DEBOUNCE - 1)) begin
                    // DEBOUNCE-th consecutive disagreeing sample: accept it.
                    r_filt[i]   <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------------- decode
    logic [N_SENSORS-1:0] w_line;
    logic                 w_prox;
    logic [CW-1:0]        w_cnt_l, w_cnt_r;
    logic                 w_none;
    logic [3:0]           w_dec;

    assign w_line = r_filt[N_SENSORS-1:0];
    assign w_prox = r_filt[NI-1];

    always_comb begin
        w_cnt_l = '0;
        w_cnt_r = '0;
        for (int i = 0; i < int'(N_SENSORS); i++) begin
            if (i > CTR) begin
                w_cnt_l = w_cnt_l + CW'(w_line[i]);
            end else if (i < CTR) begin
                w_cnt_r = w_cnt_r + CW'(w_line[i]);
            end
        end
        w_none = (w_line == '0);
        if (w_none) begin
            w_dec = DIR_STOP;
        end else if (w_cnt_l > w_cnt_r) begin
            w_dec = DIR_LEFT;
        end else if (w_cnt_r > w_cnt_l) begin
            w_dec = DIR_RIGHT;
        end else begin
            w_dec = DIR_FWD;
        end
    end

    // ---------------------------------------------------------------- FSM
    state_e        r_state;
    logic [3:0]    r_dir;
    logic [3:0]    r_last_turn;
    logic [LW-1:0] r_lost;
    logic [RW-1:0] r_resume;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_dir       <= DIR_STOP;
            r_last_turn <= DIR_RIGHT;
            r_lost      <= '0;
            r_resume    <= '0;
        end else if (!i_enable) begin
            r_state <= StIdle;
            r_dir   <= DIR_STOP;
        end else if (w_prox && (r_state inside {StFollow, StResume, StSearch})) begin
            r_state <= StObst;
            r_dir   <= DIR_STOP;
        end else begin
            case (r_state)
                StIdle: begin
                    r_state <= StFollow;
                    r_dir   <= DIR_STOP;
                    r_lost  <= '0;
                end
                StObst: begin
                    if (!w_prox) begin
                        r_state  <= StResume;
                        r_dir    <= DIR_FWD;
                        r_resume <= RW'(RESUME_CYCLES - 1);
                    end
                end
                StResume: begin
                    if (r_resume == '0) begin
                        r_state <= StFollow;
                        r_lost  <= '0;
                        if (!w_none) r_dir <= w_dec;
                    end else begin
                        r_resume <= r_resume - RW'(1);
                    end
                end
                StFollow: begin
                    if (w_none) begin
                        // Keep the previous command while the line is briefly absent.
                        if (r_lost == LW'(LOST_CYCLES - 1)) begin
                            r_state <= StSearch;
                            r_dir   <= r_last_turn;
                        end else begin
                            r_lost <= r_lost + LW'(1);
                        end
                    end else begin
                        r_lost <= '0;
                        r_dir  <= w_dec;
                        if (w_dec == DIR_LEFT || w_dec == DIR_RIGHT) r_last_turn <= w_dec;
                    end
                end
                StSearch: begin
                    if (!w_none) begin
                        r_state <= StFollow;
                        r_dir   <= w_dec;
                        r_lost  <= '0;
                    end else begin
                        r_dir <= r_last_turn;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_dir   <= DIR_STOP;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- PWM
    logic [PWM_W-1:0] r_pwm_cnt, r_duty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pwm_cnt <= '0;
            r_duty    <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            // Load on the wrap edge so the new duty covers the whole period from count 0.
            if (r_pwm_cnt == '1) r_duty <= i_speed;
        end
    end

    assign o_motor_pwm = (r_pwm_cnt < r_duty) && (r_state != StIdle) && (r_state != StObst);
    assign o_motor_dir = r_dir;
    assign o_state     = r_state;
    assign o_line_lost = (r_state == StSearch);

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Bench for line_follow_ctrl: directed scenarios plus randomized stimulus, every cycle
// compared against a behavioural model kept here.
module tb_line_follow_ctrl;

    localparam int N    = 3;
    localparam int D    = 4;
    localparam int LOST = 16;
    localparam int RES  = 8;
    localparam int PW   = 4;
    localparam int PER  = 1 << PW;

    localparam logic [3:0] STOP  = 4'b0000;
    localparam logic [3:0] FWD   = 4'b0110;
    localparam logic [3:0] LEFT  = 4'b1010;
    localparam logic [3:0] RIGHT = 4'b0101;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [N-1:0]  induct;
    logic          proxim;
    logic [PW-1:0] speed;
    logic [3:0]    motor_dir;
    logic          motor_pwm;
    logic [2:0]    state;
    logic          line_lost;

    line_follow_ctrl #(
        .N_SENSORS    (N),
        .DEBOUNCE     (D),
        .LOST_CYCLES  (LOST),
        .RESUME_CYCLES(RES),
        .PWM_W        (PW)
    ) u_dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_enable   (enable),
        .i_induct   (induct),
        .i_proxim   (proxim),
        .i_speed    (speed),
        .o_motor_dir(motor_dir),
        .o_motor_pwm(motor_pwm),
        .o_state    (state),
        .o_line_lost(line_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    // Raw input history, newest first: entry j holds the sample taken j+1 edges ago.
    logic [N:0] m_hist [$];
    logic [N:0] m_filt;
    int         m_state;       // 0 idle, 1 follow, 2 obst, 3 resume, 4 search
    logic [3:0] m_dir;
    logic [3:0] m_last;
    int         m_none_run;    // consecutive line-less cycles spent following
    int         m_res_age;     // cycles spent in resume so far
    int         m_phase;       // position within the PWM period
    int         m_duty;
    bit         m_pwm;

    task automatic model_step();
        logic [N:0]   raw_now, nf, old;
        logic [N-1:0] line;
        bit           prox, none, all_diff;
        int           l, r;
        logic [3:0]   dec;
        if (reset) begin
            m_hist.delete();
            for (int j = 0; j <= D; j++) m_hist.push_back('0);
            m_filt     = '0;
            m_state    = 0;
            m_dir      = STOP;
            m_last     = RIGHT;
            m_none_run = 0;
            m_res_age  = 0;
            m_phase    = 0;
            m_duty     = 0;
        end else begin
            raw_now = {proxim, induct};
            line    = m_filt[N-1:0];
            prox    = m_filt[N];
            l = 0;
            r = 0;
            for (int i = 0; i < N; i++) begin
                if (i > N / 2) l += int'(line[i]);
                else if (i < N / 2) r += int'(line[i]);
            end
            none = (line == '0);
            if (none) dec = STOP;
            else if (l > r) dec = LEFT;
            else if (r > l) dec = RIGHT;
            else dec = FWD;

            if (!enable) begin
                m_state = 0;
                m_dir   = STOP;
            end else if (prox && (m_state == 1 || m_state == 3 || m_state == 4)) begin
                m_state = 2;
                m_dir   = STOP;
            end else begin
                case (m_state)
                    0: begin
                        m_state    = 1;
                        m_none_run = 0;
                    end
                    2: if (!prox) begin
                        m_state   = 3;
                        m_dir     = FWD;
                        m_res_age = 0;
                    end
                    3: begin
                        m_res_age++;
                        if (m_res_age == RES) begin
                            m_state    = 1;
                            m_none_run = 0;
                            if (!none) m_dir = dec;
                        end
                    end
                    1: begin
                        if (none) begin
                            m_none_run++;
                            if (m_none_run == LOST) begin
                                m_state = 4;
                                m_dir   = m_last;
                            end
                        end else begin
                            m_none_run = 0;
                            m_dir      = dec;
                            if (dec == LEFT || dec == RIGHT) m_last = dec;
                        end
                    end
                    default: begin
                        if (!none) begin
                            m_state    = 1;
                            m_dir      = dec;
                            m_none_run = 0;
                        end else begin
                            m_dir = m_last;
                        end
                    end
                endcase
            end

            // A filtered bit flips once the synchronised samples of the last D cycles
            // (raw taken 2..D+1 edges ago) all disagree with it.
            for (int b = 0; b <= N; b++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= D; j++) begin
                    old = m_hist[j];
                    if (old[b] == m_filt[b]) all_diff = 1'b0;
                end
                nf[b] = all_diff ? ~m_filt[b] : m_filt[b];
            end
            m_filt = nf;
            m_hist.push_front(raw_now);
            void'(m_hist.pop_back());

            if (m_phase == PER - 1) m_duty = int'(speed);
            m_phase = (m_phase + 1) % PER;
        end
        m_pwm = (m_phase < m_duty) && m_state != 0 && m_state != 2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("dir", int'(motor_dir), int'(m_dir));
        check_eq("state", int'(state), m_state);
        check_eq("pwm", int'(motor_pwm), int'(m_pwm));
        check_eq("line_lost", int'(line_lost), int'(m_state == 4));
    endtask

    int hi;
    int len;

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        induct = 3'b010;
        proxim = 1'b0;
        speed  = 4'd8;

        // T1: reset and start-up
        repeat (3) begin
            tick();
            check_eq("t1_rst_state", int'(state), 0);
            check_eq("t1_rst_dir", int'(motor_dir), int'(STOP));
        end
        reset = 1'b0;
        tick();
        check_eq("t1_follow", int'(state), 1);
        repeat (5) tick();
        check_eq("t1_dir_c6", int'(motor_dir), int'(STOP));
        tick();
        check_eq("t1_dir_c7", int'(motor_dir), int'(FWD));
        repeat (3) tick();

        // T2: steer left after exactly 7 cycles, short glitch ignored
        induct = 3'b100;
        repeat (6) tick();
        check_eq("t2_dir_c6", int'(motor_dir), int'(FWD));
        tick();
        check_eq("t2_dir_c7", int'(motor_dir), int'(LEFT));
        induct = 3'b001;
        repeat (3) tick();
        induct = 3'b100;
        repeat (10) begin
            tick();
            check_eq("t2_glitch", int'(motor_dir), int'(LEFT));
        end

        // T3: obstacle together with a sensor change, then resume
        induct = 3'b001;
        proxim = 1'b1;
        repeat (20) tick();
        check_eq("t3_obst_state", int'(state), 2);
        check_eq("t3_obst_dir", int'(motor_dir), int'(STOP));
        proxim = 1'b0;
        repeat (7) tick();
        check_eq("t3_resume_state", int'(state), 3);
        check_eq("t3_resume_dir", int'(motor_dir), int'(FWD));
        repeat (7) tick();
        check_eq("t3_resume_last", int'(state), 3);
        tick();
        check_eq("t3_follow_state", int'(state), 1);
        check_eq("t3_follow_dir", int'(motor_dir), int'(RIGHT));

        // T4: lose the line after a left turn, search, recover
        induct = 3'b100;
        repeat (10) tick();
        check_eq("t4_left", int'(motor_dir), int'(LEFT));
        induct = 3'b000;
        repeat (21) tick();
        check_eq("t4_hold_state", int'(state), 1);
        check_eq("t4_hold_dir", int'(motor_dir), int'(LEFT));
        tick();
        check_eq("t4_search_state", int'(state), 4);
        check_eq("t4_search_lost", int'(line_lost), 1);
        check_eq("t4_search_dir", int'(motor_dir), int'(LEFT));
        induct = 3'b010;
        repeat (6) tick();
        check_eq("t4_still_search", int'(state), 4);
        tick();
        check_eq("t4_found_state", int'(state), 1);
        check_eq("t4_found_dir", int'(motor_dir), int'(FWD));

        // T5: PWM duty, mid-period speed change, gating in OBST
        speed = 4'd4;
        repeat (20) tick();
        hi = 0;
        repeat (16) begin
            tick();
            hi += int'(motor_pwm);
        end
        check_eq("t5_duty4", hi, 4);
        for (int k = 0; k < PER && m_phase != 8; k++) tick();
        speed = 4'd12;
        hi = 0;
        repeat (7) begin
            tick();
            hi += int'(motor_pwm);
        end
        check_eq("t5_old_duty_tail", hi, 0);
        hi = 0;
        repeat (16) begin
            tick();
            hi += int'(motor_pwm);
        end
        check_eq("t5_duty12", hi, 12);
        proxim = 1'b1;
        repeat (8) tick();
        check_eq("t5_obst", int'(state), 2);
        hi = 0;
        repeat (16) begin
            tick();
            hi += int'(motor_pwm);
        end
        check_eq("t5_obst_pwm", hi, 0);

        // T6: reset during RESUME and during SEARCH
        proxim = 1'b0;
        repeat (10) tick();
        check_eq("t6_in_resume", int'(state), 3);
        reset = 1'b1;
        tick();
        check_eq("t6_rr_state", int'(state), 0);
        check_eq("t6_rr_dir", int'(motor_dir), int'(STOP));
        check_eq("t6_rr_pwm", int'(motor_pwm), 0);
        check_eq("t6_rr_lost", int'(line_lost), 0);
        reset  = 1'b0;
        induct = 3'b000;
        repeat (25) tick();
        check_eq("t6_in_search", int'(state), 4);
        reset = 1'b1;
        tick();
        check_eq("t6_rs_state", int'(state), 0);
        check_eq("t6_rs_dir", int'(motor_dir), int'(STOP));
        check_eq("t6_rs_lost", int'(line_lost), 0);
        reset = 1'b0;

        // enable drop forces IDLE at the next edge
        induct = 3'b010;
        repeat (12) tick();
        enable = 1'b0;
        tick();
        check_eq("en_idle_state", int'(state), 0);
        check_eq("en_idle_dir", int'(motor_dir), int'(STOP));
        enable = 1'b1;

        // randomized segments
        for (int seg = 0; seg < 250; seg++) begin
            if ($urandom_range(0, 3) == 0) induct = 3'b000;
            else induct = 3'($urandom_range(0, 7));
            proxim = ($urandom_range(0, 9) == 0);
            enable = ($urandom_range(0, 19) != 0);
            speed  = 4'($urandom_range(0, 15));
            len    = int'($urandom_range(1, 40));
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            repeat (len) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
